// File: rtl/note_seq_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, note codes,
// pitch table and the default melody. The GAP state exists only with NOTE_SEQ_ARTIC_EN.
package note_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
`ifdef NOTE_SEQ_ARTIC_EN
        ST_GAP   = 3'd4,
`endif
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_END  = 5'd31;

    // Entry 0 is the lowest byte; each byte is {note[4:0], dur[2:0]}.
    typedef logic [31:0][7:0] melody_t;

    // Half-period counts, 12-TET descending from 119 (an octave halves the count).
    localparam logic [6:0] HP_TABLE [0:31] = '{
        7'd127, 7'd119, 7'd112, 7'd106, 7'd100, 7'd94,  7'd89,  7'd84,
        7'd79,  7'd75,  7'd71,  7'd67,  7'd63,  7'd60,  7'd56,  7'd53,
        7'd50,  7'd47,  7'd45,  7'd42,  7'd40,  7'd37,  7'd35,  7'd33,
        7'd32,  7'd30,  7'd28,  7'd27,  7'd25,  7'd24,  7'd22,  7'd127
    };

    localparam melody_t DEFAULT_MELODY = {
        {19{8'h00}},
        {NOTE_END, 3'd0},
        {5'd0, 3'd1}, {5'd1, 3'd3}, {5'd3, 3'd1}, {5'd5, 3'd1},
        {5'd6, 3'd1}, {5'd8, 3'd1}, {5'd0, 3'd0}, {5'd8, 3'd3},
        {5'd6, 3'd1}, {5'd5, 3'd1}, {5'd3, 3'd1}, {5'd1, 3'd1}
    };

endpackage

// File: rtl/melody_rom.sv
// 32x8 melody ROM with a registered read port (one cycle of latency).
module melody_rom
    import note_seq_pkg::*;
#(
    parameter melody_t MELODY = DEFAULT_MELODY
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_addr,
    output logic [7:0] o_data
);

    localparam melody_t ROM = MELODY;

    logic [7:0] r_data;

    // Registered ROM read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= 8'd0;
        end else begin
            r_data <= ROM[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/note_sequencer.sv
// Melody playback controller: walks melody_rom, drives hp/active per note, and
// produces the free-running synth_clk tick. Optional macro: NOTE_SEQ_ARTIC_EN (note gap).
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int      TICK_DIV  = 1000,
    parameter int      SYNTH_DIV = 16,
    parameter int      GAP_CYC   = 64,
    parameter melody_t MELODY    = DEFAULT_MELODY
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_loop_en,
    input  logic [7:0] i_tempo,
    output logic [6:0] o_hp,
    output logic       o_active,
    output logic       o_synth_clk,
    output logic       o_busy,
    output logic       o_done
);

    localparam int SUB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SYN_W = (SYNTH_DIV > 1) ? $clog2(SYNTH_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICK_DIV - 1);
    localparam logic [SYN_W-1:0] SYN_MAX = SYN_W'(SYNTH_DIV - 1);

    if (TICK_DIV < 1 || SYNTH_DIV < 1 || GAP_CYC < 1) begin : g_param_check
        $error("note_sequencer: TICK_DIV, SYNTH_DIV and GAP_CYC must be >= 1");
    end

    state_t           r_state;
    state_t           w_state_nx;
    logic [4:0]       r_addr,   w_addr_nx;
    logic [6:0]       r_hp,     w_hp_nx;
    logic             r_active, w_active_nx;
    logic             r_busy,   w_busy_nx;
    logic             r_done,   w_done_nx;
    logic [7:0]       r_tempo,  w_tempo_nx;
    logic [7:0]       r_beat,   w_beat_nx;
    logic [3:0]       r_beats,  w_beats_nx;
    logic [SUB_W-1:0] r_sub,    w_sub_nx;
    logic [SYN_W-1:0] r_syn_cnt;
    logic             r_synth_clk;
    logic [7:0]       w_rom_data;
    logic [4:0]       w_note;
    logic [2:0]       w_dur;
    logic             w_last_play;
`ifdef NOTE_SEQ_ARTIC_EN
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC - 1);
    logic [GAP_W-1:0] r_gap, w_gap_nx;
`endif

    melody_rom #(
        .MELODY (MELODY)
    ) u_rom (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_addr (r_addr),
        .o_data (w_rom_data)
    );

    assign w_note      = w_rom_data[7:3];
    assign w_dur       = w_rom_data[2:0];
    // Last cycle of the note: final sub-tick of the final tempo step of the final beat.
    assign w_last_play = (r_sub == SUB_MAX) && (r_beat == r_tempo) && (r_beats == 4'd1);

    // Next-state and next-output logic of the playback FSM.
    always_comb begin
        w_state_nx  = r_state;
        w_addr_nx   = r_addr;
        w_hp_nx     = r_hp;
        w_active_nx = r_active;
        w_done_nx   = 1'b0;
        w_tempo_nx  = r_tempo;
        w_beat_nx   = r_beat;
        w_beats_nx  = r_beats;
        w_sub_nx    = r_sub;
`ifdef NOTE_SEQ_ARTIC_EN
        w_gap_nx    = r_gap;
`endif
        if (i_stop) begin
            w_state_nx  = ST_IDLE;
            w_active_nx = 1'b0;
            w_addr_nx   = 5'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        w_state_nx = ST_FETCH;
                        w_addr_nx  = 5'd0;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ST_FETCH: begin
                    w_state_nx = ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_note == NOTE_END) begin
                        if (i_loop_en) begin
                            w_addr_nx  = 5'd0;
                            w_state_nx = ST_FETCH;
                        end else begin
                            w_active_nx = 1'b0;
                            w_done_nx   = 1'b1;
                            w_state_nx  = ST_DONE;
                        end
                    end else begin
                        if (w_note == NOTE_REST) begin
                            w_active_nx = 1'b0;
                        end else begin
                            w_hp_nx     = HP_TABLE[w_note];
                            w_active_nx = 1'b1;
                        end
                        w_beats_nx = {1'b0, w_dur} + 4'd1;
                        w_tempo_nx = i_tempo;
                        w_beat_nx  = 8'd0;
                        w_sub_nx   = {SUB_W{1'b0}};
                        w_state_nx = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_last_play) begin
                        w_addr_nx = r_addr + 5'd1;
`ifdef NOTE_SEQ_ARTIC_EN
                        w_state_nx  = ST_GAP;
                        w_active_nx = 1'b0;
                        w_gap_nx    = {GAP_W{1'b0}};
`else
                        w_state_nx  = ST_FETCH;
`endif
                    end else if (r_sub == SUB_MAX) begin
                        w_sub_nx = {SUB_W{1'b0}};
                        if (r_beat == r_tempo) begin
                            w_beat_nx  = 8'd0;
                            w_beats_nx = r_beats - 4'd1;
                        end else begin
                            w_beat_nx  = r_beat + 8'd1;
                        end
                    end else begin
                        w_sub_nx = r_sub + SUB_W'(1);
                    end
                end
`ifdef NOTE_SEQ_ARTIC_EN
                ST_GAP: begin
                    if (r_gap == GAP_MAX) begin
                        w_state_nx = ST_FETCH;
                    end else begin
                        w_gap_nx   = r_gap + GAP_W'(1);
                    end
                end
`endif
                default: begin
                    w_state_nx  = ST_IDLE;
                    w_active_nx = 1'b0;
                    w_addr_nx   = 5'd0;
                end
            endcase
        end
        w_busy_nx = (w_state_nx != ST_IDLE) && (w_state_nx != ST_DONE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= 5'd0;
            r_hp     <= 7'd127;
            r_active <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tempo  <= 8'd0;
            r_beat   <= 8'd0;
            r_beats  <= 4'd0;
            r_sub    <= {SUB_W{1'b0}};
`ifdef NOTE_SEQ_ARTIC_EN
            r_gap    <= {GAP_W{1'b0}};
`endif
        end else begin
            r_state  <= w_state_nx;
            r_addr   <= w_addr_nx;
            r_hp     <= w_hp_nx;
            r_active <= w_active_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_tempo  <= w_tempo_nx;
            r_beat   <= w_beat_nx;
            r_beats  <= w_beats_nx;
            r_sub    <= w_sub_nx;
`ifdef NOTE_SEQ_ARTIC_EN
            r_gap    <= w_gap_nx;
`endif
        end
    end

    // Free-running synth tick; deliberately ignores stop and the FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_syn_cnt   <= {SYN_W{1'b0}};
            r_synth_clk <= 1'b0;
        end else if (r_syn_cnt == SYN_MAX) begin
            r_syn_cnt   <= {SYN_W{1'b0}};
            r_synth_clk <= ~r_synth_clk;
        end else begin
            r_syn_cnt   <= r_syn_cnt + SYN_W'(1);
        end
    end

    assign o_hp        = r_hp;
    assign o_active    = r_active;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_synth_clk = r_synth_clk;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: per-cycle expected {hp,active,busy,done}
// are queued as stimulus is driven and popped/compared on the falling edge.
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int SYNTH_DIV = 2;
    localparam int GAP_CYC   = 2;
`ifdef NOTE_SEQ_ARTIC_EN
    localparam bit ARTIC = 1'b1;
`else
    localparam bit ARTIC = 1'b0;
`endif

    // addr0 {1,d0}, addr1 {13,d1}, addr2 rest d0, addr3 {25,d2}, addr4 end.
    localparam melody_t TB_MELODY = {
        {27{8'h00}},
        {NOTE_END, 3'd0},
        {5'd25, 3'd2},
        {5'd0, 3'd0},
        {5'd13, 3'd1},
        {5'd1, 3'd0}
    };

    typedef struct packed {
        logic [6:0] hp;
        logic       active;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop_en;
    logic [7:0] tempo;
    logic [6:0] hp;
    logic       active, synth_clk, busy, done;

    obs_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   step_no = 0;

    note_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .SYNTH_DIV (SYNTH_DIV),
        .GAP_CYC   (GAP_CYC),
        .MELODY    (TB_MELODY)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_loop_en   (loop_en),
        .i_tempo     (tempo),
        .o_hp        (hp),
        .o_active    (active),
        .o_synth_clk (synth_clk),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_obs(input string tag, input obs_t got, input obs_t want);
        n_total = n_total + 1;
        assert (got === want) n_pass = n_pass + 1;
        else $error("FAIL %s step %0d: observed hp=%0d active=%0b busy=%0b done=%0b, expected hp=%0d active=%0b busy=%0b done=%0b",
                    tag, step_no, got.hp, got.active, got.busy, got.done,
                    want.hp, want.active, want.busy, want.done);
    endtask

    task automatic check_bit(input string tag, input logic got, input logic want);
        n_total = n_total + 1;
        assert (got === want) n_pass = n_pass + 1;
        else $error("FAIL %s step %0d: observed %0b expected %0b", tag, step_no, got, want);
    endtask

    task automatic push(input logic [6:0] e_hp, input logic e_act, input logic e_busy,
                        input logic e_done, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{hp: e_hp, active: e_act, busy: e_busy, done: e_done});
        end
    endtask

    // Cycles between notes: optional silent gap, then FETCH/LOAD with outputs held.
    task automatic push_between(input logic [6:0] e_hp, input logic e_act, input int n_fl);
        if (ARTIC) begin
            push(e_hp, 1'b0, 1'b1, 1'b0, GAP_CYC);
            push(e_hp, 1'b0, 1'b1, 1'b0, n_fl);
        end else begin
            push(e_hp, e_act, 1'b1, 1'b0, n_fl);
        end
    endtask

    task automatic run(input string tag);
        obs_t want;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            step_no = step_no + 1;
            want = exp_q.pop_front();
            check_obs(tag, '{hp: hp, active: active, busy: busy, done: done}, want);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; tempo = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_obs("reset", '{hp: hp, active: active, busy: busy, done: done},
                  '{hp: 7'd127, active: 1'b0, busy: 1'b0, done: 1'b0});
        check_bit("reset_sclk", synth_clk, 1'b0);

        // Idle: outputs hold reset values, synth_clk toggles every SYNTH_DIV cycles.
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            step_no = step_no + 1;
            check_obs("idle", '{hp: hp, active: active, busy: busy, done: done},
                      '{hp: 7'd127, active: 1'b0, busy: 1'b0, done: 1'b0});
            check_bit("sclk", synth_clk, 1'(((i / SYNTH_DIV) % 2)));
        end

        // Full song, no loop; tempo raised to 2 before the last note's LOAD.
        start = 1'b1;
        push(7'd127, 1'b0, 1'b1, 1'b0, 1);
        run("song_fetch");
        start = 1'b0;
        push(7'd127, 1'b0, 1'b1, 1'b0, 1);
        push(7'd119, 1'b1, 1'b1, 1'b0, 4);
        push_between(7'd119, 1'b1, 2);
        push(7'd60, 1'b1, 1'b1, 1'b0, 8);
        push_between(7'd60, 1'b1, 2);
        push(7'd60, 1'b0, 1'b1, 1'b0, 4);
        run("song_a");
        tempo = 8'd2;
        push_between(7'd60, 1'b0, 2);
        push(7'd30, 1'b1, 1'b1, 1'b0, 36);
        run("song_long");
        tempo = 8'd0;
        push_between(7'd30, 1'b1, 2);
        push(7'd30, 1'b0, 1'b0, 1'b1, 1);
        push(7'd30, 1'b0, 1'b0, 1'b0, 3);
        run("song_done");

        // Same song looping: no done, busy never drops across the wrap.
        start = 1'b1;
        loop_en = 1'b1;
        push(7'd30, 1'b0, 1'b1, 1'b0, 1);
        run("loop_fetch");
        start = 1'b0;
        push(7'd30, 1'b0, 1'b1, 1'b0, 1);
        push(7'd119, 1'b1, 1'b1, 1'b0, 4);
        push_between(7'd119, 1'b1, 2);
        push(7'd60, 1'b1, 1'b1, 1'b0, 8);
        push_between(7'd60, 1'b1, 2);
        push(7'd60, 1'b0, 1'b1, 1'b0, 4);
        run("loop_a");
        tempo = 8'd2;
        push_between(7'd60, 1'b0, 2);
        push(7'd30, 1'b1, 1'b1, 1'b0, 36);
        run("loop_long");
        tempo = 8'd0;
        push_between(7'd30, 1'b1, 2);
        push(7'd30, ARTIC ? 1'b0 : 1'b1, 1'b1, 1'b0, 2);
        push(7'd119, 1'b1, 1'b1, 1'b0, 4);
        push_between(7'd119, 1'b1, 2);
        push(7'd60, 1'b1, 1'b1, 1'b0, 3);
        run("loop_wrap");

        // Stop mid-note: silent and idle next cycle, hp held.
        stop = 1'b1;
        push(7'd60, 1'b0, 1'b0, 1'b0, 1);
        run("stop");
        stop = 1'b0;
        push(7'd60, 1'b0, 1'b0, 1'b0, 2);
        run("stop_idle");

        // Stop and start together: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        push(7'd60, 1'b0, 1'b0, 1'b0, 2);
        run("stop_prio");
        stop = 1'b0;

        // Restart plays from address 0.
        push(7'd60, 1'b0, 1'b1, 1'b0, 1);
        run("restart_fetch");
        start = 1'b0;
        push(7'd60, 1'b0, 1'b1, 1'b0, 1);
        push(7'd119, 1'b1, 1'b1, 1'b0, 2);
        run("restart");

        // Reset mid-note returns everything to reset values.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step_no = step_no + 1;
        check_obs("rst_mid", '{hp: hp, active: active, busy: busy, done: done},
                  '{hp: 7'd127, active: 1'b0, busy: 1'b0, done: 1'b0});
        check_bit("rst_mid_sclk", synth_clk, 1'b0);
        rst = 1'b0;
        push(7'd127, 1'b0, 1'b0, 1'b0, 3);
        run("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Melody playback controller that sits directly upstream of the square-wave frequency synthesiser. It walks a 32-entry melody ROM, converts each note code to a 7-bit half-period through a pitch table, and holds `hp`/`active` for the note's duration. It also generates the free-running `synth_clk` tick that the synthesiser counts. Control is start/stop/loop from the top level; there is no other bus.

## Interface
- `TICK_DIV`, 1000: clk cycles per tempo sub-tick; must be ≥1.
- `SYNTH_DIV`, 16: clk cycles per `synth_clk` half-period; must be ≥1.
- `GAP_CYC`, 64: silent clk cycles inserted after each note when articulation is compiled in; must be ≥1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE or DONE only.
- `stop`  in  1  level; forces IDLE from any state and has priority over `start`.
- `loop_en`  in  1  restart at address 0 on the end marker.
- `tempo`  in  8  beat length multiplier; sampled in LOAD.
- `hp`  out  7  half-period count for the synthesiser.
- `active`  out  1  synthesiser output enable.
- `synth_clk`  out  1  50% duty tick for the synthesiser.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  one-cycle pulse when the song ends without looping.

## Operation
- ROM entry is 8 bits: `[7:3]` note code, `[2:0]` duration code.
  - Note code 0 is a rest.
  - Note codes 1..30 are pitches.
  - Note code 31 is the end marker.
- ROM read is registered, with 1-cycle latency.
- States: IDLE, FETCH, LOAD, PLAY, GAP (only with the macro), DONE.
- IDLE/DONE → FETCH on `start`, with `addr`=0.
- FETCH: issue the ROM read; → LOAD.
- LOAD, end marker:
  - `loop_en`=1: `addr`←0, → FETCH.
  - `loop_en`=0: `active`←0, `done` pulses, → DONE.
- LOAD, rest: `active`←0, `hp` unchanged.
- LOAD, pitch: `hp`←`HP_TABLE[code]`, `active`←1.
- LOAD, rest or pitch:
  - `beats`←dur+1.
  - Latch `tempo`.
  - Clear the prescalers.
  - → PLAY.
- PLAY length is exactly (dur+1)·(tempo+1)·`TICK_DIV` cycles.
  - Sub-tick counter runs 0..`TICK_DIV`-1.
  - Beat counter runs 0..tempo.
  - On the final beat's last cycle: `addr`←`addr`+1 (5-bit wrap 31→0), then → GAP or FETCH.
- GAP: `active`=0 for `GAP_CYC` cycles, then → FETCH.
- `stop` in any state: → IDLE, `active`←0, `addr`←0, `hp` held.
- `synth_clk` is independent of the FSM. It toggles every `SYNTH_DIV` clk cycles from reset and is unaffected by `stop`.
- A ROM with no end marker wraps at address 31→0 and plays forever, regardless of `loop_en`.

## Timing
- Reset values: `hp`=127, `active`=0, `synth_clk`=0, `busy`=0, `done`=0; state IDLE, `addr`=0.
- `start` high in cycle t:
  - FETCH in t+1.
  - LOAD in t+2.
  - New `hp`/`active` visible in t+3.
- Note-to-note pitch switch without the macro: two cycles of FETCH/LOAD between notes, with the previous `hp`/`active` held.
- All outputs are registered.
- `done` is high only in the cycle after the end-marker LOAD.
- `stop` and `start` high together: `stop` wins.
- `rst` mid-note: all outputs return to reset values the next cycle.

## Configuration
- `NOTE_SEQ_ARTIC_EN` defined: GAP state present; every note, including rests, is followed by `GAP_CYC` cycles of `active`=0.
- `NOTE_SEQ_ARTIC_EN` not defined: no GAP state; PLAY goes straight to FETCH; `GAP_CYC` is unused.

## Structure
- Package `note_seq_pkg` holds:
  - The state enum.
  - `NOTE_REST`=0 and `NOTE_END`=31.
  - `HP_TABLE[0:31]`, 7-bit entries. Codes 1..30 follow a 12-TET descent from 119, with code 13 = 60 and code 25 = 30. Entries 0 and 31 are 127.
- Sub-module `melody_rom`: 32×8 synchronous ROM, address in, registered data out. The melody contents are a localparam array.

## Test plan
Bench settings: `TICK_DIV`=4, `SYNTH_DIV`=2, `GAP_CYC`=2, `tempo`=0.
- Reset, then idle 20 cycles → `hp`=127, `active`=0, `busy`=0; `synth_clk` toggles every 2 cycles.
- ROM {code 1, dur 0}, {END}, `loop_en`=0, `start` pulse at t → `hp`=119 and `active`=1 from t+3 for exactly 4 cycles; `done` pulses once; state DONE.
- ROM {13/dur 1}, {0/dur 0}, {END}, macro on → `hp`=60 for 8 cycles; 2 gap cycles; 4 cycles of `active`=0 rest; 2 gap cycles; `done`.
- Same ROM with `loop_en`=1 → pattern repeats; `done` never asserts; `busy` stays 1.
- `stop` asserted mid-PLAY → `active`=0 and `busy`=0 next cycle; the following `start` plays from address 0.
- `tempo`=2, {25/dur 2} → `hp`=30 held for exactly 3·3·4=36 cycles.
